cbv_fifo_port: RTL and testbench



---
 rtl/cbv_pkg.sv | 18 +
 rtl/cbv_sync_fifo.sv | 54 +++++
 rtl/cbv_fifo_port.sv | 174 +++++++++++++++++
 tb/tb_cbv_fifo_port.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbv_pkg.sv
// Shared types and constants for the cern-be-vme
// single-word FIFO port.
package cbv_pkg;

  localparam int CBV_DW = 32;

  typedef logic [CBV_DW-1:0] cbv_word_t;

  typedef enum logic {
    WR_IDLE,
    WR_WAIT
  } cbv_wr_state_t;

  localparam int ST_UNDERFLOW = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_PROTO     = 2;

endpackage

// File: rtl/cbv_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// A push into a full FIFO is taken only with a simultaneous pop.
module cbv_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rp];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/cbv_fifo_port.sv
// VME single-word submap port: host writes feed TX,
// host reads drain RX, with local write back-pressure.
module cbv_fifo_port
  import cbv_pkg::*;
#(
  parameter int        DEPTH      = 16,
  parameter int        WR_TIMEOUT = 255,
  parameter cbv_word_t EMPTY_WORD = 32'hDEAD_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [31:0]            VMERdData_o,
  input  logic [31:0]            VMEWrData_i,
  input  logic                   VMERdMem_i,
  input  logic                   VMEWrMem_i,
  output logic                   VMERdDone_o,
  output logic                   VMEWrDone_o,
  output logic [31:0]            tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  input  logic [31:0]            rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [$clog2(DEPTH):0] tx_count_o,
  output logic [$clog2(DEPTH):0] rx_count_o,
  output logic [2:0]             status_o,
  input  logic                   status_clr_i
);

  localparam int TW = $clog2(WR_TIMEOUT + 1);

  cbv_word_t     rx_head;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_pop;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_push;
  cbv_word_t     tx_wdata;

  cbv_wr_state_t state;
  cbv_wr_state_t state_d;
  logic [TW-1:0] cnt;
  logic [TW-1:0] cnt_d;
  cbv_word_t     word;
  cbv_word_t     word_d;
  logic          done_d;
  logic          ovf_set;
  logic          proto_set;
  logic [2:0]    st_set;

  assign rx_pop     = VMERdMem_i && !rx_empty;
  assign rx_ready_o = !rx_full;
  assign tx_valid_o = !tx_empty;

  cbv_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CBV_DW)
  ) u_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_valid_i),
    .wdata (rx_data_i),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count_o),
    .head  (rx_head)
  );

  cbv_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CBV_DW)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .wdata (tx_wdata),
    .pop   (tx_ready_i),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count_o),
    .head  (tx_data_o)
  );

  // Read path: one-cycle response, empty reads return a marker.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      VMERdData_o <= '0;
      VMERdDone_o <= 1'b0;
    end else begin
      VMERdDone_o <= VMERdMem_i;
      if (VMERdMem_i) begin
        VMERdData_o <= rx_empty ? EMPTY_WORD : rx_head;
      end
    end
  end

  // Write FSM registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WR_IDLE;
      cnt         <= '0;
      word        <= '0;
      VMEWrDone_o <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      word        <= word_d;
      VMEWrDone_o <= done_d;
    end
  end

  // Write FSM: push, park while full, or drop on timeout.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    word_d    = word;
    tx_push   = 1'b0;
    tx_wdata  = VMEWrData_i;
    done_d    = 1'b0;
    ovf_set   = 1'b0;
    proto_set = 1'b0;
    case (state)
      WR_IDLE: begin
        if (VMEWrMem_i) begin
          if (!tx_full) begin
            tx_push = 1'b1;
            done_d  = 1'b1;
          end else begin
            word_d  = VMEWrData_i;
            cnt_d   = TW'(WR_TIMEOUT);
            state_d = WR_WAIT;
          end
        end
      end
      WR_WAIT: begin
        proto_set = VMEWrMem_i;
        if (!tx_full) begin
          tx_push  = 1'b1;
          tx_wdata = word;
          done_d   = 1'b1;
          state_d  = WR_IDLE;
        end else if (cnt == TW'(1)) begin
          done_d  = 1'b1;
          ovf_set = 1'b1;
          state_d = WR_IDLE;
        end else begin
          cnt_d = cnt - TW'(1);
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // Collect sticky status set events.
  always_comb begin
    st_set               = '0;
    st_set[ST_UNDERFLOW] = VMERdMem_i && rx_empty;
    st_set[ST_OVERFLOW]  = ovf_set;
    st_set[ST_PROTO]     = proto_set;
  end

  // Sticky status: a set event wins over a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_o <= '0;
    end else begin
      status_o <= (status_clr_i ? 3'b000 : status_o)
                | st_set;
    end
  end

endmodule

// File: tb/tb_cbv_fifo_port.sv
// Self-checking bench for cbv_fifo_port: queue-based
// reference model plus a short-timeout instance.
module tb_cbv_fifo_port;

  localparam int D  = 16;
  localparam int T  = 255;
  localparam logic [31:0] EW = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rd_data;
  logic [31:0] wd;
  logic        rd, wr, rd_done, wr_done;
  logic [31:0] tx_data;
  logic        tx_valid, txr;
  logic [31:0] rxd;
  logic        rxv, rx_ready;
  logic [4:0]  tx_count, rx_count;
  logic [2:0]  status;
  logic        clr;

  logic        b_rst_n, b_wr, b_txr;
  logic [31:0] b_wd;
  logic [31:0] b_rdd, b_txd;
  logic        b_rdone, b_wdone, b_txv, b_rxr;
  logic [4:0]  b_txc, b_rxc;
  logic [2:0]  b_st;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rxq[$];
  logic [31:0] txq[$];
  bit          m_wait;
  logic [31:0] m_pend;
  int          m_left;
  logic [2:0]  m_st;
  logic        m_rdd, m_wrd;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  cbv_fifo_port dut (
    .clk(clk), .rst_n(rst_n),
    .VMERdData_o(rd_data), .VMEWrData_i(wd),
    .VMERdMem_i(rd), .VMEWrMem_i(wr),
    .VMERdDone_o(rd_done), .VMEWrDone_o(wr_done),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid),
    .tx_ready_i(txr), .rx_data_i(rxd),
    .rx_valid_i(rxv), .rx_ready_o(rx_ready),
    .tx_count_o(tx_count), .rx_count_o(rx_count),
    .status_o(status), .status_clr_i(clr)
  );

  cbv_fifo_port #(.WR_TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .VMERdData_o(b_rdd), .VMEWrData_i(b_wd),
    .VMERdMem_i(1'b0), .VMEWrMem_i(b_wr),
    .VMERdDone_o(b_rdone), .VMEWrDone_o(b_wdone),
    .tx_data_o(b_txd), .tx_valid_o(b_txv),
    .tx_ready_i(b_txr), .rx_data_i(32'h0),
    .rx_valid_i(1'b0), .rx_ready_o(b_rxr),
    .tx_count_o(b_txc), .rx_count_o(b_rxc),
    .status_o(b_st), .status_clr_i(1'b0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Reference behaviour applied at each rising edge.
  task automatic model_edge();
    int rxs, txs;
    logic [2:0] set;
    logic [31:0] junk;
    if (!rst_n) begin
      rxq.delete(); txq.delete();
      m_wait = 0; m_st = 0;
      m_rdd = 0; m_wrd = 0; m_rdata = 0;
      return;
    end
    rxs = rxq.size(); txs = txq.size();
    set = 0;
    m_rdd = rd; m_wrd = 0;
    if (rd) begin
      if (rxs > 0) m_rdata = rxq.pop_front();
      else begin m_rdata = EW; set[0] = 1; end
    end
    if (rxv && (rxs < D || (rd && rxs > 0)))
      rxq.push_back(rxd);
    if (txr && txs > 0) junk = txq.pop_front();
    if (!m_wait) begin
      if (wr) begin
        if (txs < D) begin
          txq.push_back(wd); m_wrd = 1;
        end else begin
          m_wait = 1; m_pend = wd; m_left = T;
        end
      end
    end else begin
      if (wr) set[2] = 1;
      if (txs < D) begin
        txq.push_back(m_pend);
        m_wrd = 1; m_wait = 0;
      end else if (m_left == 1) begin
        m_wrd = 1; set[1] = 1; m_wait = 0;
      end else begin
        m_left--;
      end
    end
    m_st = (clr ? 3'b000 : m_st) | set;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("rd_done", 32'(rd_done), 32'(m_rdd));
    chk("rd_data", rd_data, m_rdata);
    chk("wr_done", 32'(wr_done), 32'(m_wrd));
    chk("tx_count", 32'(tx_count), 32'(txq.size()));
    chk("rx_count", 32'(rx_count), 32'(rxq.size()));
    chk("tx_valid", 32'(tx_valid),
        32'(txq.size() > 0));
    chk("rx_ready", 32'(rx_ready),
        32'(rxq.size() < D));
    if (txq.size() > 0)
      chk("tx_data", tx_data, txq[0]);
    chk("status", 32'(status), 32'(m_st));
  endtask

  task automatic cyc(input logic r, input logic w,
                     input logic [31:0] d,
                     input logic tr, input logic v,
                     input logic [31:0] vd,
                     input logic c);
    rd = r; wr = w; wd = d; txr = tr;
    rxv = v; rxd = vd; clr = c;
    step();
    rd = 0; wr = 0; txr = 0; rxv = 0; clr = 0;
  endtask

  initial begin
    int got, nd, at;
    logic [31:0] lastw;
    bit seen_bb;
    rst_n = 0; rd = 0; wr = 0; wd = 0; txr = 0;
    rxv = 0; rxd = 0; clr = 0;
    b_rst_n = 0; b_wr = 0; b_wd = 0; b_txr = 0;
    step(); step();
    rst_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);

    cyc(0, 0, 0, 0, 1, 32'h1111_1111, 0);
    cyc(0, 0, 0, 0, 1, 32'h2222_2222, 0);
    chk("rx_cnt2", 32'(rx_count), 2);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rd1", rd_data, 32'h1111_1111);
    chk("rd1_done", 32'(rd_done), 1);
    chk("rx_cnt1", 32'(rx_count), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rd2", rd_data, 32'h2222_2222);
    chk("rx_cnt0", 32'(rx_count), 0);

    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rd_empty", rd_data, 32'hDEAD_0000);
    chk("st_uflow", 32'(status), 32'b001);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("st_clr", 32'(status), 0);

    for (int i = 0; i < 16; i++)
      cyc(0, 1, 32'(i), 0, 0, 0, 0);
    chk("tx_full_cnt", 32'(tx_count), 16);
    chk("tx_full_val", 32'(tx_valid), 1);
    chk("tx_full_head", tx_data, 0);

    cyc(0, 1, 32'hAAAA, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    got = 0;
    for (int k = 0; k < 2; k++) begin
      if (got == 0) begin
        cyc(0, 0, 0, 0, 0, 0, 0);
        if (wr_done) got = 1;
      end
    end
    chk("aaaa_done", 32'(got), 1);
    lastw = 0;
    for (int i = 0; i < 16; i++) begin
      lastw = tx_data;
      cyc(0, 0, 0, 1, 0, 0, 0);
    end
    chk("aaaa_last", lastw, 32'hAAAA);
    chk("drain_cnt", 32'(tx_count), 0);
    chk("aaaa_st", 32'(status), 0);

    for (int i = 0; i < 16; i++)
      cyc(0, 0, 0, 0, 1, 32'(i + 256), 0);
    chk("rx_full_rdy", 32'(rx_ready), 0);
    cyc(1, 0, 0, 0, 1, 32'h999, 0);
    chk("rx_pp_cnt", 32'(rx_count), 16);
    chk("rx_pp_rdy", 32'(rx_ready), 0);
    chk("rx_pp_data", rd_data, 32'h100);

    for (int i = 0; i < 16; i++)
      cyc(0, 1, 32'(i), 0, 0, 0, 0);
    cyc(0, 1, 32'h5555, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    rst_n = 0;
    step();
    chk("rst_wdone", 32'(wr_done), 0);
    chk("rst_txc", 32'(tx_count), 0);
    chk("rst_rxc", 32'(rx_count), 0);
    rst_n = 1;
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 5) == 0,
          $urandom_range(0, 1) == 0, $urandom,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) != 0, $urandom,
          $urandom_range(0, 31) == 0);
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 1) == 0,
          $urandom_range(0, 5) == 0, $urandom,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 4) == 0, $urandom,
          $urandom_range(0, 31) == 0);

    @(negedge clk); @(negedge clk);
    b_rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      b_wr = 1; b_wd = 32'(i);
      @(negedge clk);
      chk("b_fill_done", 32'(b_wdone), 1);
    end
    b_wr = 1; b_wd = 32'hBBBB;
    nd = 0; at = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (b_wdone) begin nd++; at = i; end
      b_wr = (i == 2); b_wd = 32'h1234;
    end
    chk("b_done_cnt", 32'(nd), 1);
    chk("b_done_at", 32'(at), 5);
    chk("b_status", 32'(b_st), 32'b110);
    chk("b_txc", 32'(b_txc), 16);
    seen_bb = 0; lastw = 0;
    for (int i = 0; i < 16; i++) begin
      lastw = b_txd;
      if (b_txd == 32'hBBBB) seen_bb = 1;
      b_txr = 1;
      @(negedge clk);
    end
    b_txr = 0;
    chk("b_no_bbbb", 32'(seen_bb), 0);
    chk("b_last", lastw, 15);
    chk("b_empty", 32'(b_txc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
